// File: rtl/banco_registros_pkg.sv
// Shared widths and output-channel state encoding for the register bank.
package banco_registros_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } estado_salida_t;

endpackage

// File: rtl/banco_registros_puerto_salida.sv
// Output-port channel: latches a byte on request and holds it under valid/ack.
module puerto_salida
  import banco_registros_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              out_en,
  input  logic              ack,
  input  logic [DATA_W-1:0] dato,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              overrun
);

  estado_salida_t    state_reg, state_next;
  logic [DATA_W-1:0] data_reg;
  logic              overrun_reg;
  logic              load;
  logic              set_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      data_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) data_reg <= dato;
      if (set_overrun) overrun_reg <= 1'b1;
    end
  end

  // A request arriving while occupied is never loaded, even if ack frees the channel that cycle.
  always_comb begin
    state_next  = state_reg;
    load        = 1'b0;
    set_overrun = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (out_en) begin
          load       = 1'b1;
          state_next = ST_VALID;
        end
      end
      ST_VALID: begin
        if (out_en) set_overrun = 1'b1;
        if (ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign data_out       = data_reg;
  assign data_out_valid = (state_reg == ST_VALID);
  assign busy           = data_out_valid;
  assign overrun        = overrun_reg;

endmodule

// File: rtl/banco_registros.sv
// Eight-entry register bank with write-forwarding read ports and an output-port channel.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Dato_Registro,
  input  logic              WE,
  input  logic [ADDR_W-1:0] DirW,
  input  logic [ADDR_W-1:0] DirX,
  input  logic [ADDR_W-1:0] DirY,
  output logic [DATA_W-1:0] RX,
  output logic [DATA_W-1:0] RY,
  input  logic              OUT_EN,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataOut_Valid,
  input  logic              DataOut_Ack,
  output logic              Busy,
  output logic              Overrun
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (WE) begin
      regs[DirW] <= Dato_Registro;
    end
  end

  // Forward the incoming write so the selector and ALU see it in the same cycle.
  assign RX = (WE && (DirW == DirX)) ? Dato_Registro : regs[DirX];
  assign RY = (WE && (DirW == DirY)) ? Dato_Registro : regs[DirY];

  puerto_salida #(
    .DATA_W(DATA_W)
  ) u_puerto_salida (
    .clk           (clk),
    .rst_n         (rst_n),
    .out_en        (OUT_EN),
    .ack           (DataOut_Ack),
    .dato          (RX),
    .data_out      (DataOut),
    .data_out_valid(DataOut_Valid),
    .busy          (Busy),
    .overrun       (Overrun)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Directed, table-driven check of the register bank and its output handshake.
module tb_banco_registros;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dato;
  logic       we;
  logic [2:0] dirw, dirx, diry;
  logic [7:0] rx, ry, data_out;
  logic       out_en, ack, valid, busy, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banco_registros dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Dato_Registro(dato),
    .WE           (we),
    .DirW         (dirw),
    .DirX         (dirx),
    .DirY         (diry),
    .RX           (rx),
    .RY           (ry),
    .OUT_EN       (out_en),
    .DataOut      (data_out),
    .DataOut_Valid(valid),
    .DataOut_Ack  (ack),
    .Busy         (busy),
    .Overrun      (overrun)
  );

  typedef struct {
    logic       we;
    logic [2:0] dirw;
    logic [7:0] dato;
    logic [2:0] dirx;
    logic [2:0] diry;
    logic       oe;
    logic       ack;
    logic [7:0] rx;
    logic [7:0] ry;
    logic [7:0] dout;
    logic       v;
    logic       o;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h required=%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] a, input logic [7:0] d,
                       input logic [2:0] x, input logic [2:0] y, input logic oe, input logic k);
    we = w; dirw = a; dato = d; dirx = x; diry = y; out_en = oe; ack = k;
  endtask

  initial begin
    // Registered outputs are checked before the edge, so they reflect earlier rows.
    //            we dirw dato   dx dy oe ack  rx     ry     dout   v  o
    vecs[0]  = '{1, 3, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0};
    vecs[1]  = '{1, 0, 8'h11, 3, 1, 0, 0, 8'hA5, 8'h00, 8'h00, 0, 0};
    vecs[2]  = '{1, 7, 8'h3C, 0, 3, 0, 0, 8'h11, 8'hA5, 8'h00, 0, 0};
    vecs[3]  = '{0, 0, 8'hFF, 3, 7, 0, 0, 8'hA5, 8'h3C, 8'h00, 0, 0};
    vecs[4]  = '{1, 2, 8'h10, 0, 0, 0, 0, 8'h11, 8'h11, 8'h00, 0, 0};
    vecs[5]  = '{1, 2, 8'h55, 2, 2, 0, 0, 8'h55, 8'h55, 8'h00, 0, 0};
    vecs[6]  = '{0, 2, 8'hEE, 2, 2, 0, 0, 8'h55, 8'h55, 8'h00, 0, 0};
    vecs[7]  = '{1, 5, 8'h9E, 5, 6, 0, 0, 8'h9E, 8'h00, 8'h00, 0, 0};
    vecs[8]  = '{0, 0, 8'h00, 5, 2, 1, 0, 8'h9E, 8'h55, 8'h00, 0, 0};
    vecs[9]  = '{0, 0, 8'h00, 5, 2, 0, 0, 8'h9E, 8'h55, 8'h9E, 1, 0};
    vecs[10] = '{1, 5, 8'h77, 0, 0, 0, 0, 8'h11, 8'h11, 8'h9E, 1, 0};
    vecs[11] = '{0, 0, 8'h00, 5, 5, 0, 0, 8'h77, 8'h77, 8'h9E, 1, 0};
    vecs[12] = '{0, 0, 8'h00, 3, 7, 0, 0, 8'hA5, 8'h3C, 8'h9E, 1, 0};
    vecs[13] = '{0, 0, 8'h00, 3, 7, 0, 1, 8'hA5, 8'h3C, 8'h9E, 1, 0};
    vecs[14] = '{0, 0, 8'h00, 3, 7, 0, 0, 8'hA5, 8'h3C, 8'h9E, 0, 0};
    vecs[15] = '{0, 0, 8'h00, 5, 7, 1, 0, 8'h77, 8'h3C, 8'h9E, 0, 0};
    vecs[16] = '{1, 1, 8'h01, 1, 1, 1, 0, 8'h01, 8'h01, 8'h77, 1, 0};
    vecs[17] = '{0, 0, 8'h00, 1, 1, 1, 1, 8'h01, 8'h01, 8'h77, 1, 1};
    vecs[18] = '{0, 0, 8'h00, 1, 0, 0, 1, 8'h01, 8'h11, 8'h77, 0, 1};
    vecs[19] = '{1, 6, 8'hC7, 6, 1, 1, 0, 8'hC7, 8'h01, 8'h77, 0, 1};
    vecs[20] = '{0, 0, 8'h00, 6, 1, 0, 0, 8'hC7, 8'h01, 8'hC7, 1, 1};

    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Dirty the bank, then reset mid-run and sweep every address.
    @(posedge clk); #1 drive(1, 4, 8'hFF, 0, 0, 0, 0);
    @(posedge clk); #1 drive(1, 0, 8'hEE, 0, 0, 1, 0);
    @(posedge clk); #1 drive(0, 0, 8'h00, 4, 0, 0, 0);
    #2 chk("pre_reset_r4", rx, 8'hFF);
    chk("pre_reset_valid", {7'd0, valid}, 8'h01);
    rst_n = 1'b0;
    #1 chk("reset_async_valid", {7'd0, valid}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      dirx = 3'(a);
      diry = 3'(7 - a);
      #1;
      chk($sformatf("reset_rx_%0d", a), rx, 8'h00);
      chk($sformatf("reset_ry_%0d", 7 - a), ry, 8'h00);
    end
    chk("reset_dout", data_out, 8'h00);
    chk("reset_valid", {7'd0, valid}, 8'h00);
    chk("reset_ovr", {7'd0, overrun}, 8'h00);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1 drive(vecs[i].we, vecs[i].dirw, vecs[i].dato, vecs[i].dirx, vecs[i].diry,
               vecs[i].oe, vecs[i].ack);
      #2;
      chk($sformatf("v%0d_rx", i), rx, vecs[i].rx);
      chk($sformatf("v%0d_ry", i), ry, vecs[i].ry);
      chk($sformatf("v%0d_dout", i), data_out, vecs[i].dout);
      chk($sformatf("v%0d_valid", i), {7'd0, valid}, {7'd0, vecs[i].v});
      chk($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].v});
      chk($sformatf("v%0d_ovr", i), {7'd0, overrun}, {7'd0, vecs[i].o});
      $display("vec %0d: rx=%02h ry=%02h dout=%02h valid=%0b ovr=%0b", i, rx, ry, data_out,
               valid, overrun);
    end

    // Asynchronous reset between edges while a byte is pending.
    @(posedge clk); #1 drive(0, 0, 8'h00, 6, 5, 0, 0);
    #2 chk("mid_valid_before", {7'd0, valid}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", {7'd0, valid}, 8'h00);
    chk("mid_reset_dout", data_out, 8'h00);
    chk("mid_reset_ovr", {7'd0, overrun}, 8'h00);
    chk("mid_reset_r6", rx, 8'h00);
    chk("mid_reset_r5", ry, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_valid", {7'd0, valid}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
